load_mem_unit: RTL and testbench
================================

// Module: load_mem_unit
// PURPOSE
//   Load execution stage directly downstream of the load queue. Takes the oldest
//   ready load offered by the LQ (address, ROB index, destination physical register).
//   Pops that load from the LQ. Issues one word read to data memory over a req/gnt +
//   rvalid handshake. Delivers the loaded data to writeback with a valid/ready handshake.
//   At most one load is in flight. Pipeline flush is supported, including a response
//   that is still outstanding when the flush arrives.
// PARAMETERS
//   ADDR_LEN     32  load address width (matches `ADDR_LEN)
//   DATA_LEN     32  memory data width
//   ROB_SEL       6  ROB index width (matches `ROB_SEL)
//   PHY_REG_SEL   6  physical register index width (matches `PHY_REG_SEL)
// PORTS
//   clk           in   1            clock, rising edge
//   reset_n       in   1            asynchronous, active-low reset
//   lq_ld_valid   in   1            LQ offers a load with address computed
//   lq_ld_addr    in   ADDR_LEN     load address
//   lq_ld_rob     in   ROB_SEL      ROB index of the load
//   lq_ld_dst     in   PHY_REG_SEL  destination physical register
//   lq_ld_pop     out  1            load accepted this cycle; LQ advances its head
//   flush         in   1            squash all in-flight work
//   dmem_req      out  1            memory read request
//   dmem_addr     out  ADDR_LEN     request address, word aligned
//   dmem_gnt      in   1            request accepted
//   dmem_rvalid   in   1            read data valid; never in the same cycle as its gnt
//   dmem_rdata    in   DATA_LEN     read data
//   wb_valid      out  1            result available
//   wb_ready      in   1            writeback accepts the result
//   wb_data       out  DATA_LEN     loaded data; 0 when wb_exc = 1
//   wb_rob        out  ROB_SEL      ROB index of the result
//   wb_dst        out  PHY_REG_SEL  destination register of the result
//   wb_exc        out  1            misaligned-address exception
//   busy          out  1            state != IDLE
// BEHAVIOUR
//   Reset (reset_n = 0, asynchronous):
//     - state = IDLE; all registered outputs and capture registers = 0.
//     - Reset wins over any operation in progress. A response arriving after reset
//       is ignored, because IDLE treats dmem_rvalid as don't-care.
//   States:
//     - IDLE: accept condition is lq_ld_valid & !flush.
//         - lq_ld_pop = accept (combinational; the only combinational output).
//         - On accept, capture addr, rob and dst.
//         - If addr[1:0] != 0: go to RESP with exc = 1 and data = 0.
//         - Otherwise go to REQ.
//     - REQ: dmem_req = 1 and dmem_addr = captured addr; both hold stable until dmem_gnt.
//         - gnt & !flush: go to WAIT.
//         - gnt & flush: go to DRAIN.
//         - !gnt & flush: go to IDLE.
//     - WAIT: dmem_req = 0.
//         - dmem_rvalid & !flush: capture rdata, go to RESP.
//         - dmem_rvalid & flush: go to IDLE.
//         - !dmem_rvalid & flush: go to DRAIN.
//     - RESP: wb_valid = 1; data, rob, dst and exc are held stable until wb_ready.
//         - wb_ready: go to IDLE.
//         - flush: go to IDLE and the result is dropped; flush has priority over wb_ready.
//     - DRAIN: wait for dmem_rvalid, discard the data, go to IDLE. Further flushes in
//       DRAIN are ignored. No LQ pop happens until the unit is back in IDLE.
//   Timing and ordering:
//     - Best-case latency: accept at cycle 0, req at cycle 1 (gnt same cycle),
//       rvalid at cycle 2, wb_valid at cycle 3.
//     - One new load can be accepted every 4 cycles at best.
//     - Loads complete in LQ order; there are never more than 1 outstanding memory
//       requests.
//   Boundary rules:
//     - lq_ld_valid is ignored in every state except IDLE.
//     - An LQ that is empty (lq_ld_valid = 0) leaves the unit in IDLE with no pop.
//     - wb_ready held low stalls the unit in RESP indefinitely.
//     - Data and exception fields are registered. No X propagates while wb_valid = 0,
//       because the fields are driven from the capture registers.
// TESTING
//   1. Single load: addr 0x100, rob 5, dst 12; gnt at cycle 1, rvalid with 0xDEADBEEF
//      at cycle 2 -> pop at cycle 0 only; wb_valid at cycle 3 with data 0xDEADBEEF,
//      rob 5, dst 12, exc 0.
//   2. Back-pressure: gnt delayed 3 cycles, wb_ready low for 2 cycles -> dmem_req and
//      addr stable until gnt; wb fields stable until wb_ready; exactly one pop.
//   3. Misaligned addr 0x102 -> no dmem_req; wb_valid at cycle 1 with exc 1 and data 0.
//   4. Flush in WAIT, then rvalid 2 cycles later -> state goes to DRAIN; the data is
//      discarded; no wb_valid; the next load is accepted the cycle after rvalid.
//   5. Flush in REQ without gnt -> state returns to IDLE, no wb_valid.
//      Flush in RESP with wb_ready = 1 -> result dropped.
//   6. reset_n pulsed low in WAIT -> all outputs 0 immediately; a stray rvalid after
//      reset produces no wb_valid.

Source files
------------

// File: rtl/load_mem_unit_if.sv
// Bundle of LQ, data-memory and writeback signals for the load execution stage.
// master = the load unit, slave = its environment (LQ, memory, writeback, control).
interface load_mem_unit_if #(
   parameter int ADDR_LEN    = 32,
   parameter int DATA_LEN    = 32,
   parameter int ROB_SEL     = 6,
   parameter int PHY_REG_SEL = 6
) ();
   logic                   lq_ld_valid;
   logic [ADDR_LEN-1:0]    lq_ld_addr;
   logic [ROB_SEL-1:0]     lq_ld_rob;
   logic [PHY_REG_SEL-1:0] lq_ld_dst;
   logic                   lq_ld_pop;
   logic                   flush;
   logic                   dmem_req;
   logic [ADDR_LEN-1:0]    dmem_addr;
   logic                   dmem_gnt;
   logic                   dmem_rvalid;
   logic [DATA_LEN-1:0]    dmem_rdata;
   logic                   wb_valid;
   logic                   wb_ready;
   logic [DATA_LEN-1:0]    wb_data;
   logic [ROB_SEL-1:0]     wb_rob;
   logic [PHY_REG_SEL-1:0] wb_dst;
   logic                   wb_exc;
   logic                   busy;

   modport master (
      input  lq_ld_valid, lq_ld_addr, lq_ld_rob, lq_ld_dst, flush,
      input  dmem_gnt, dmem_rvalid, dmem_rdata, wb_ready,
      output lq_ld_pop, dmem_req, dmem_addr,
      output wb_valid, wb_data, wb_rob, wb_dst, wb_exc, busy
   );

   modport slave (
      output lq_ld_valid, lq_ld_addr, lq_ld_rob, lq_ld_dst, flush,
      output dmem_gnt, dmem_rvalid, dmem_rdata, wb_ready,
      input  lq_ld_pop, dmem_req, dmem_addr,
      input  wb_valid, wb_data, wb_rob, wb_dst, wb_exc, busy
   );
endinterface

// File: rtl/load_mem_unit.sv
// Load execution stage: pops one load from the LQ, reads one word from data memory
// and hands the result to writeback. At most one load in flight; flush-safe.
module load_mem_unit #(
   parameter int ADDR_LEN    = 32,
   parameter int DATA_LEN    = 32,
   parameter int ROB_SEL     = 6,
   parameter int PHY_REG_SEL = 6
) (
   input  logic            clk,
   input  logic            reset_n,
   load_mem_unit_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_LEN-3:0]    addr_q, addr_d;
   logic [ROB_SEL-1:0]     rob_q, rob_d;
   logic [PHY_REG_SEL-1:0] dst_q, dst_d;
   logic [DATA_LEN-1:0]    data_q, data_d;
   logic                   exc_q, exc_d;
   logic                   req_q, req_d;
   logic                   wb_valid_q, wb_valid_d;
   logic                   busy_q, busy_d;
   logic                   pop;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rob_d   = rob_q;
      dst_d   = dst_q;
      data_d  = data_q;
      exc_d   = exc_q;
      pop     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.lq_ld_valid && !bus.flush) begin
               pop    = 1'b1;
               addr_d = bus.lq_ld_addr[ADDR_LEN-1:2];
               rob_d  = bus.lq_ld_rob;
               dst_d  = bus.lq_ld_dst;
               data_d = '0;
               // Misaligned loads never touch memory; they retire as an exception.
               if (bus.lq_ld_addr[1:0] != 2'b00) begin
                  exc_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  exc_d   = 1'b0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (bus.dmem_gnt) begin
               state_d = bus.flush ? S_DRAIN : S_WAIT;
            end else if (bus.flush) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (bus.dmem_rvalid) begin
               if (!bus.flush) begin
                  data_d  = bus.dmem_rdata;
                  state_d = S_RESP;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (bus.flush) begin
               // Granted request still owes a response; swallow it before reuse.
               state_d = S_DRAIN;
            end
         end
         S_RESP: begin
            if (bus.flush || bus.wb_ready) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (bus.dmem_rvalid) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      req_d      = (state_d == S_REQ);
      wb_valid_d = (state_d == S_RESP);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rob_q      <= '0;
         dst_q      <= '0;
         data_q     <= '0;
         exc_q      <= 1'b0;
         req_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rob_q      <= rob_d;
         dst_q      <= dst_d;
         data_q     <= data_d;
         exc_q      <= exc_d;
         req_q      <= req_d;
         wb_valid_q <= wb_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.lq_ld_pop = pop;
   assign bus.dmem_req  = req_q;
   assign bus.dmem_addr = {addr_q, 2'b00};
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_data   = data_q;
   assign bus.wb_rob    = rob_q;
   assign bus.wb_dst    = dst_q;
   assign bus.wb_exc    = exc_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_load_mem_unit.sv
// Directed bench for load_mem_unit: stimulus pushes expected writeback results into a
// scoreboard queue, a separate monitor pops and compares on every wb handshake.
module tb_load_mem_unit;
   typedef struct packed {
      logic [31:0] data;
      logic [5:0]  rob;
      logic [5:0]  dst;
      logic        exc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   failures = 0;
   int   pops = 0;
   int   p0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   load_mem_unit_if bus ();

   load_mem_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.lq_ld_valid = 1'b0;
      bus.lq_ld_addr  = '0;
      bus.lq_ld_rob   = '0;
      bus.lq_ld_dst   = '0;
      bus.flush       = 1'b0;
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = '0;
      bus.wb_ready    = 1'b0;
   endtask

   task automatic offer(input logic [31:0] a, input logic [5:0] r, input logic [5:0] d);
      bus.lq_ld_valid = 1'b1;
      bus.lq_ld_addr  = a;
      bus.lq_ld_rob   = r;
      bus.lq_ld_dst   = d;
   endtask

   task automatic expect_wb(input logic [31:0] data, input logic [5:0] r,
                            input logic [5:0] d, input logic e);
      exp_t x;
      x.data = data;
      x.rob  = r;
      x.dst  = d;
      x.exc  = e;
      exp_q.push_back(x);
   endtask

   // Pop counter: a pop is an LQ handshake completing at the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         if (reset_n === 1'b1 && bus.lq_ld_pop === 1'b1) pops++;
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1 &&
             bus.flush === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL wb_unexpected: got data=0x%0h rob=%0d dst=%0d exc=%0b required none",
                        bus.wb_data, bus.wb_rob, bus.wb_dst, bus.wb_exc);
            end else begin
               e = exp_q.pop_front();
               $display("wb: data=0x%08h rob=%0d dst=%0d exc=%0b (exp 0x%08h %0d %0d %0b)",
                        bus.wb_data, bus.wb_rob, bus.wb_dst, bus.wb_exc,
                        e.data, e.rob, e.dst, e.exc);
               check("wb_data", 64'(bus.wb_data), 64'(e.data));
               check("wb_rob",  64'(bus.wb_rob),  64'(e.rob));
               check("wb_dst",  64'(bus.wb_dst),  64'(e.dst));
               check("wb_exc",  64'(bus.wb_exc),  64'(e.exc));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      step();
      mid();
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_req", 64'(bus.dmem_req), 64'd0);
      check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
      check("rst_wb_data", 64'(bus.wb_data), 64'd0);
      check("rst_pop", 64'(bus.lq_ld_pop), 64'd0);
      step();
      reset_n = 1'b1;
      step();
      mid();
      check("idle_empty_lq_pop", 64'(bus.lq_ld_pop), 64'd0);
      step();

      // 1: single load, best-case latency
      p0 = pops;
      offer(32'h100, 6'd5, 6'd12);
      expect_wb(32'hDEADBEEF, 6'd5, 6'd12, 1'b0);
      mid(); check("t1_pop_c0", 64'(bus.lq_ld_pop), 64'd1); step();
      bus.lq_ld_valid = 1'b0; bus.dmem_gnt = 1'b1;
      mid(); check("t1_req_c1", 64'(bus.dmem_req), 64'd1);
      check("t1_addr_c1", 64'(bus.dmem_addr), 64'h100); step();
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
      mid(); check("t1_req_c2", 64'(bus.dmem_req), 64'd0);
      check("t1_wbv_c2", 64'(bus.wb_valid), 64'd0); step();
      bus.dmem_rvalid = 1'b0; bus.wb_ready = 1'b1;
      mid(); check("t1_wbv_c3", 64'(bus.wb_valid), 64'd1); step();
      bus.wb_ready = 1'b0;
      mid(); check("t1_busy_c4", 64'(bus.busy), 64'd0);
      check("t1_pops", 64'(pops - p0), 64'd1); step();

      // 2: gnt delayed 3 cycles, wb_ready low 2 cycles, LQ keeps offering meanwhile
      p0 = pops;
      offer(32'h200, 6'd7, 6'd3);
      expect_wb(32'h12345678, 6'd7, 6'd3, 1'b0);
      step();
      offer(32'h240, 6'd8, 6'd9);
      for (int c = 1; c <= 3; c++) begin
         mid(); check("t2_req_hold", 64'(bus.dmem_req), 64'd1);
         check("t2_addr_hold", 64'(bus.dmem_addr), 64'h200);
         check("t2_no_pop", 64'(bus.lq_ld_pop), 64'd0); step();
      end
      bus.dmem_gnt = 1'b1;
      mid(); check("t2_req_gnt", 64'(bus.dmem_req), 64'd1); step();
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
      step();
      bus.dmem_rvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         mid(); check("t2_wbv_stall", 64'(bus.wb_valid), 64'd1);
         check("t2_data_stall", 64'(bus.wb_data), 64'h12345678);
         check("t2_rob_stall", 64'(bus.wb_rob), 64'd7); step();
      end
      bus.lq_ld_valid = 1'b0; bus.wb_ready = 1'b1;
      step();
      bus.wb_ready = 1'b0;
      mid(); check("t2_busy_end", 64'(bus.busy), 64'd0);
      check("t2_pops", 64'(pops - p0), 64'd1); step();

      // 3: misaligned address
      offer(32'h102, 6'd9, 6'd4);
      expect_wb(32'h0, 6'd9, 6'd4, 1'b1);
      mid(); check("t3_pop", 64'(bus.lq_ld_pop), 64'd1); step();
      bus.lq_ld_valid = 1'b0; bus.wb_ready = 1'b1;
      mid(); check("t3_no_req", 64'(bus.dmem_req), 64'd0);
      check("t3_wbv_c1", 64'(bus.wb_valid), 64'd1);
      check("t3_exc", 64'(bus.wb_exc), 64'd1); step();
      bus.wb_ready = 1'b0;
      mid(); check("t3_busy_end", 64'(bus.busy), 64'd0); step();

      // 4: flush in WAIT, rvalid 2 cycles later, next load waits for the drain
      offer(32'h300, 6'd1, 6'd1);
      step();
      bus.lq_ld_valid = 1'b0; bus.dmem_gnt = 1'b1;
      step();
      bus.dmem_gnt = 1'b0; bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      offer(32'h400, 6'd2, 6'd2);
      mid(); check("t4_drain_busy", 64'(bus.busy), 64'd1);
      check("t4_drain_pop", 64'(bus.lq_ld_pop), 64'd0);
      check("t4_drain_wbv", 64'(bus.wb_valid), 64'd0); step();
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h00BADBAD;
      mid(); check("t4_rvalid_pop", 64'(bus.lq_ld_pop), 64'd0); step();
      bus.dmem_rvalid = 1'b0;
      expect_wb(32'h44444444, 6'd2, 6'd2, 1'b0);
      mid(); check("t4_next_pop", 64'(bus.lq_ld_pop), 64'd1);
      check("t4_no_stale_wbv", 64'(bus.wb_valid), 64'd0); step();
      bus.lq_ld_valid = 1'b0; bus.dmem_gnt = 1'b1;
      mid(); check("t4_next_addr", 64'(bus.dmem_addr), 64'h400); step();
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h44444444;
      step();
      bus.dmem_rvalid = 1'b0; bus.wb_ready = 1'b1;
      mid(); check("t4_wbv", 64'(bus.wb_valid), 64'd1); step();
      bus.wb_ready = 1'b0;
      step();

      // 5a: flush in REQ without gnt
      offer(32'h500, 6'd3, 6'd6);
      step();
      bus.lq_ld_valid = 1'b0; bus.flush = 1'b1;
      mid(); check("t5a_req", 64'(bus.dmem_req), 64'd1); step();
      bus.flush = 1'b0;
      mid(); check("t5a_busy", 64'(bus.busy), 64'd0);
      check("t5a_req_off", 64'(bus.dmem_req), 64'd0);
      check("t5a_wbv", 64'(bus.wb_valid), 64'd0); step();

      // 5b: flush in RESP together with wb_ready drops the result
      offer(32'h600, 6'd4, 6'd8);
      step();
      bus.lq_ld_valid = 1'b0; bus.dmem_gnt = 1'b1;
      step();
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
      step();
      bus.dmem_rvalid = 1'b0; bus.flush = 1'b1; bus.wb_ready = 1'b1;
      mid(); check("t5b_wbv_resp", 64'(bus.wb_valid), 64'd1); step();
      bus.flush = 1'b0; bus.wb_ready = 1'b0;
      mid(); check("t5b_wbv_after", 64'(bus.wb_valid), 64'd0);
      check("t5b_busy", 64'(bus.busy), 64'd0); step();

      // 6: async reset in WAIT, stray rvalid afterwards
      offer(32'h700, 6'd10, 6'd11);
      step();
      bus.lq_ld_valid = 1'b0; bus.dmem_gnt = 1'b1;
      step();
      bus.dmem_gnt = 1'b0;
      #2;
      check("t6_wait_busy", 64'(bus.busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("t6_rst_busy", 64'(bus.busy), 64'd0);
      check("t6_rst_req", 64'(bus.dmem_req), 64'd0);
      check("t6_rst_wbv", 64'(bus.wb_valid), 64'd0);
      check("t6_rst_rob", 64'(bus.wb_rob), 64'd0);
      check("t6_rst_dst", 64'(bus.wb_dst), 64'd0);
      check("t6_rst_addr", 64'(bus.dmem_addr), 64'd0);
      step();
      reset_n = 1'b1;
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h77777777; bus.wb_ready = 1'b1;
      mid(); check("t6_stray_wbv", 64'(bus.wb_valid), 64'd0); step();
      bus.dmem_rvalid = 1'b0;
      mid(); check("t6_stray_wbv2", 64'(bus.wb_valid), 64'd0);
      check("t6_busy_after", 64'(bus.busy), 64'd0); step();
      bus.wb_ready = 1'b0;
      step();

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
